equation_accumulate: RTL and testbench

Parametrised Wishbone bus-master sum engine for the DSP equation slot. On `equation_enable` it reads `equation_length` consecutive 32-bit words starting at `base_address` and accumulates them, signed or unsigned, wrapping or saturating. It writes the result to the word immediately following the operands and reports completion or bus error to the equation controller.

---
 rtl/dsp_pkg.sv | 16 +
 rtl/equation_accumulate_if.sv | 28 ++
 rtl/equation_accum.sv | 64 ++++++
 rtl/equation_accumulate.sv | 192 +++++++++++++++++++
 tb/tb_equation_accumulate.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// Types and constants shared by the DSP equation engines.
package dsp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } eq_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [3:0] SEL_WORD    = 4'hF;

endpackage

// File: rtl/equation_accumulate_if.sv
// Wishbone classic-cycle bus bundle; signal suffixes follow the master's view.
interface equation_accumulate_if #(
   parameter int dw = 32,
   parameter int aw = 32
);
   logic [aw-1:0] wb_adr_o;
   logic [dw-1:0] wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic [dw-1:0] wb_dat_i;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic          wb_rty_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );
endinterface

// File: rtl/equation_accum.sv
// Wide accumulator with clear, add-enable, sign/zero extension and an optional
// saturating dw-bit output stage.
module equation_accum #(
   parameter int dw = 32,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          add_en,
   input  logic          is_signed,
   input  logic          saturate,
   input  logic [dw-1:0] operand,
   output logic [dw-1:0] result
);
   localparam int AW = dw + LW;

   logic [AW-1:0] acc_q, acc_d, ext_s;
   logic [LW:0]   top_s;

   // next accumulator value; LW guard bits mean the sum of 2^LW-1 operands never overflows
   always_comb begin
      ext_s = is_signed ? {{LW{operand[dw-1]}}, operand} : {{LW{1'b0}}, operand};
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (add_en) begin
         acc_d = acc_q + ext_s;
      end else begin
         acc_d = acc_q;
      end
   end

   // accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // signed overflow shows as guard bits differing from the dw-1 sign bit
   always_comb begin
      top_s  = acc_q[AW-1:dw-1];
      result = acc_q[dw-1:0];
      if (!saturate) begin
         result = acc_q[dw-1:0];
      end else if (is_signed) begin
         if ((top_s != '0) && (top_s != '1)) begin
            result = acc_q[AW-1] ? {1'b1, {(dw-1){1'b0}}} : {1'b0, {(dw-1){1'b1}}};
         end else begin
            result = acc_q[dw-1:0];
         end
      end else begin
         if (acc_q[AW-1:dw] != '0) begin
            result = '1;
         end else begin
            result = acc_q[dw-1:0];
         end
      end
   end

endmodule

// File: rtl/equation_accumulate.sv
// Wishbone bus-master sum engine: reads equation_length words from base_address,
// accumulates them and writes the result to the following word.
module equation_accumulate
   import dsp_pkg::*;
#(
   parameter int dw        = 32,
   parameter int aw        = 32,
   parameter int LW        = 8,
   parameter int MAX_RETRY = 3
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst_n,
   equation_accumulate_if.master wb,
   input  logic [aw-1:0]         base_address,
   input  logic [LW-1:0]         equation_length,
   input  logic                  equation_signed,
   input  logic                  equation_saturate,
   input  logic                  equation_enable,
   output logic                  equation_done,
   output logic                  equation_error
);
   localparam int RW = $clog2(MAX_RETRY + 2);

   eq_state_e     state_q, state_d;
   logic [LW-1:0] idx_q, idx_d, len_q, len_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [aw-1:0] base_q, base_d, adr_q, adr_d;
   logic          signed_q, signed_d, sat_q, sat_d;
   logic          cyc_q, cyc_d, we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [dw-1:0] dat_q, dat_d;
   logic          done_q, done_d, error_q, error_d;

   logic          ack_s, err_s, rty_s, term_s;
   logic          acc_clr_s, acc_add_s;
   logic [dw-1:0] result_s;
   logic [aw-1:0] rd_adr_s, wr_adr_s;

   assign ack_s    = cyc_q & wb.wb_ack_i;
   assign err_s    = cyc_q & wb.wb_err_i;
   assign rty_s    = cyc_q & wb.wb_rty_i;
   assign term_s   = ack_s | err_s | rty_s;
   assign rd_adr_s = base_q + aw'({idx_q, 2'b00});
   assign wr_adr_s = base_q + aw'({len_q, 2'b00});

   equation_accum #(.dw(dw), .LW(LW)) u_accum (
      .clk       (wb_clk),
      .rst_n     (wb_rst_n),
      .clr       (acc_clr_s),
      .add_en    (acc_add_s),
      .is_signed (signed_q),
      .saturate  (sat_q),
      .operand   (wb.wb_dat_i),
      .result    (result_s)
   );

   // sequencing: operand index, retry budget and state transitions
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      retry_d   = retry_q;
      base_d    = base_q;
      signed_d  = signed_q;
      sat_d     = sat_q;
      acc_clr_s = 1'b0;
      acc_add_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (equation_enable) begin
               base_d    = base_address;
               len_d     = equation_length;
               signed_d  = equation_signed;
               sat_d     = equation_saturate;
               idx_d     = '0;
               retry_d   = '0;
               acc_clr_s = 1'b1;
               state_d   = (equation_length != '0) ? ST_READ : ST_WRITE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ, ST_WRITE: begin
            // err outranks a simultaneous ack
            if (err_s) begin
               state_d = ST_ERROR;
            end else if (ack_s) begin
               retry_d = '0;
               if (state_q == ST_WRITE) begin
                  state_d = ST_DONE;
               end else begin
                  acc_add_s = 1'b1;
                  if (idx_q == len_q - LW'(1)) begin
                     state_d = ST_WRITE;
                  end else begin
                     idx_d = idx_q + LW'(1);
                  end
               end
            end else if (rty_s) begin
               if (retry_q == RW'(MAX_RETRY)) begin
                  state_d = ST_ERROR;
               end else begin
                  retry_d = retry_q + RW'(1);
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_DONE, ST_ERROR: state_d = equation_enable ? state_q : ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
   end

   // bus drive: launch one access per idle cycle, drop everything on any termination
   always_comb begin
      cyc_d = cyc_q;
      we_d  = we_q;
      sel_d = sel_q;
      adr_d = adr_q;
      dat_d = dat_q;
      if (term_s) begin
         cyc_d = 1'b0;
         we_d  = 1'b0;
         sel_d = '0;
         adr_d = '0;
         dat_d = '0;
      end else if (!cyc_q && (state_q == ST_READ)) begin
         cyc_d = 1'b1;
         we_d  = 1'b0;
         sel_d = SEL_WORD;
         adr_d = rd_adr_s;
         dat_d = '0;
      end else if (!cyc_q && (state_q == ST_WRITE)) begin
         cyc_d = 1'b1;
         we_d  = 1'b1;
         sel_d = SEL_WORD;
         adr_d = wr_adr_s;
         dat_d = result_s;
      end else begin
         cyc_d = cyc_q;
      end
      done_d  = (state_q == ST_DONE);
      error_d = (state_q == ST_ERROR);
   end

   // state and output registers
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         retry_q  <= '0;
         base_q   <= '0;
         signed_q <= 1'b0;
         sat_q    <= 1'b0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         retry_q  <= retry_d;
         base_q   <= base_d;
         signed_q <= signed_d;
         sat_q    <= sat_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign wb.wb_cyc_o    = cyc_q;
   assign wb.wb_stb_o    = cyc_q;
   assign wb.wb_we_o     = we_q;
   assign wb.wb_sel_o    = sel_q;
   assign wb.wb_adr_o    = adr_q;
   assign wb.wb_dat_o    = dat_q;
   assign wb.wb_cti_o    = CTI_CLASSIC;
   assign wb.wb_bte_o    = BTE_LINEAR;
   assign equation_done  = done_q;
   assign equation_error = error_q;

endmodule

// File: tb/tb_equation_accumulate.sv
// Directed bench for equation_accumulate: zero-wait Wishbone slave with scripted
// err/rty responses, expected-access queue from an arithmetic model, literal pins.
module tb_equation_accumulate;

   localparam int R_ACK = 0;
   localparam int R_ERR = 1;
   localparam int R_RTY = 2;

   logic        wb_clk;
   logic        wb_rst_n;
   logic [31:0] base_address;
   logic [7:0]  equation_length;
   logic        equation_signed;
   logic        equation_saturate;
   logic        equation_enable;
   logic        equation_done;
   logic        equation_error;

   equation_accumulate_if #(.dw(32), .aw(32)) bus ();

   equation_accumulate #(.dw(32), .aw(32), .LW(8), .MAX_RETRY(3)) dut (
      .wb_clk            (wb_clk),
      .wb_rst_n          (wb_rst_n),
      .wb                (bus),
      .base_address      (base_address),
      .equation_length   (equation_length),
      .equation_signed   (equation_signed),
      .equation_saturate (equation_saturate),
      .equation_enable   (equation_enable),
      .equation_done     (equation_done),
      .equation_error    (equation_error)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] op_buf [0:15];
   logic [31:0] exp_adr [$];
   logic [31:0] exp_dat [$];
   bit          exp_we  [$];
   int          plan    [$];
   int          strobe_cnt = 0;
   int          wr_cnt     = 0;
   logic [31:0] last_wr_adr = 32'h0;
   logic [31:0] last_wr_dat = 32'h0;
   int          resp_s;
   bit          ok_s;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sum of the operands in plain 64-bit arithmetic, then wrap or clamp.
   function automatic logic [31:0] model_result(input int n, input bit sgn, input bit sat);
      longint s = 0;
      for (int i = 0; i < n; i++)
         s += sgn ? longint'($signed(op_buf[i])) : longint'(op_buf[i]);
      if (sat && sgn && (s > 64'sh0000_0000_7FFF_FFFF)) return 32'h7FFF_FFFF;
      if (sat && sgn && (s < 64'shFFFF_FFFF_8000_0000)) return 32'h8000_0000;
      if (sat && !sgn && (s > 64'sh0000_0000_FFFF_FFFF)) return 32'hFFFF_FFFF;
      return s[31:0];
   endfunction

   // Slave and per-cycle compare: every strobe is matched against the expected access queue.
   always @(negedge wb_clk) begin
      ok_s = !(equation_done && equation_error) &&
             !((equation_done || equation_error) && bus.wb_cyc_o) &&
             (bus.wb_stb_o == bus.wb_cyc_o) && (bus.wb_cti_o == 3'b000) && (bus.wb_bte_o == 2'b00);
      check("bus_invariants", 64'(ok_s), 64'd1);
      if (bus.wb_cyc_o) begin
         strobe_cnt++;
         n_tests++;
         if (exp_adr.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_access: got adr 0x%0h we %0d, expected no access", bus.wb_adr_o, bus.wb_we_o);
         end else begin
            check("acc_adr", bus.wb_adr_o, exp_adr[0]);
            check("acc_we", 64'(bus.wb_we_o), 64'(exp_we[0]));
            check("acc_sel", bus.wb_sel_o, 64'hF);
            if (exp_we[0]) check("acc_wdat", bus.wb_dat_o, exp_dat[0]);
         end
         resp_s = (plan.size() > 0) ? plan.pop_front() : R_ACK;
         bus.wb_dat_i = mem.exists(bus.wb_adr_o) ? mem[bus.wb_adr_o] : 32'h0;
         bus.wb_ack_i = (resp_s == R_ACK);
         bus.wb_err_i = (resp_s == R_ERR);
         bus.wb_rty_i = (resp_s == R_RTY);
         if (resp_s == R_ACK) begin
            if (bus.wb_we_o) begin
               mem[bus.wb_adr_o] = bus.wb_dat_o;
               last_wr_adr = bus.wb_adr_o;
               last_wr_dat = bus.wb_dat_o;
               wr_cnt++;
            end
            if (exp_adr.size() > 0) begin
               void'(exp_adr.pop_front());
               void'(exp_dat.pop_front());
               void'(exp_we.pop_front());
            end
         end
      end else begin
         bus.wb_dat_i = 32'h0;
         bus.wb_ack_i = 1'b0;
         bus.wb_err_i = 1'b0;
         bus.wb_rty_i = 1'b0;
      end
   end

   task automatic flush();
      exp_adr.delete();
      exp_dat.delete();
      exp_we.delete();
      plan.delete();
   endtask

   task automatic start_op(input logic [31:0] base, input int n, input bit sgn, input bit sat);
      for (int i = 0; i < n; i++) begin
         mem[base + 32'(4 * i)] = op_buf[i];
         exp_adr.push_back(base + 32'(4 * i));
         exp_dat.push_back(32'h0);
         exp_we.push_back(1'b0);
      end
      exp_adr.push_back(base + 32'(4 * n));
      exp_dat.push_back(model_result(n, sgn, sat));
      exp_we.push_back(1'b1);
      strobe_cnt  = 0;
      wr_cnt      = 0;
      last_wr_adr = 32'hDEAD_BEEF;
      last_wr_dat = 32'hDEAD_BEEF;
      @(posedge wb_clk);
      #1;
      base_address      = base;
      equation_length   = 8'(n);
      equation_signed   = sgn;
      equation_saturate = sat;
      equation_enable   = 1'b1;
   endtask

   task automatic wait_end(output int cycles);
      cycles = 0;
      do begin
         @(posedge wb_clk);
         #1;
         cycles++;
      end while (!(equation_done || equation_error) && (cycles < 1000));
      check("end_reached", 64'(equation_done | equation_error), 64'd1);
   endtask

   task automatic finish_op();
      equation_enable = 1'b0;
      repeat (2) begin
         @(posedge wb_clk);
         #1;
      end
      check("back_to_idle", {equation_done, equation_error}, 64'd0);
      flush();
   endtask

   task automatic run_full(input string tag, input logic [31:0] base, input int n, input bit sgn,
                           input bit sat, input logic [31:0] lit, input int extra);
      int c;
      start_op(base, n, sgn, sat);
      wait_end(c);
      check({tag, "_done"}, 64'(equation_done), 64'd1);
      check({tag, "_latency"}, 64'(c), 64'(2 * (n + 1) + 2 + extra));
      check({tag, "_wr_adr"}, last_wr_adr, base + 32'(4 * n));
      check({tag, "_wr_dat"}, last_wr_dat, lit);
      check({tag, "_strobes"}, 64'(strobe_cnt), 64'(n + 1 + extra / 2));
      finish_op();
   endtask

   initial begin
      int c;
      wb_rst_n          = 1'b0;
      equation_enable   = 1'b0;
      base_address      = 32'h0;
      equation_length   = 8'h0;
      equation_signed   = 1'b0;
      equation_saturate = 1'b0;
      @(posedge wb_clk);
      #1;
      check("rst_ctrl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 64'd0);
      check("rst_adr", bus.wb_adr_o, 64'd0);
      check("rst_dat", bus.wb_dat_o, 64'd0);
      check("rst_sel_cti_bte", {bus.wb_sel_o, bus.wb_cti_o, bus.wb_bte_o}, 64'd0);
      check("rst_done_err", {equation_done, equation_error}, 64'd0);
      @(negedge wb_clk);
      wb_rst_n = 1'b1;

      op_buf[0] = 32'd1; op_buf[1] = 32'd2; op_buf[2] = 32'd3; op_buf[3] = 32'd4;
      run_full("uns4", 32'h100, 4, 1'b0, 1'b0, 32'd10, 0);

      op_buf[0] = 32'h7FFF_FFFF; op_buf[1] = 32'h0000_0001;
      run_full("s_sat_hi", 32'h300, 2, 1'b1, 1'b1, 32'h7FFF_FFFF, 0);
      run_full("s_wrap_hi", 32'h300, 2, 1'b1, 1'b0, 32'h8000_0000, 0);

      op_buf[0] = 32'h8000_0000; op_buf[1] = 32'hFFFF_FFFF;
      run_full("s_sat_lo", 32'h340, 2, 1'b1, 1'b1, 32'h8000_0000, 0);
      run_full("s_wrap_lo", 32'h340, 2, 1'b1, 1'b0, 32'h7FFF_FFFF, 0);

      op_buf[0] = 32'hFFFF_FFFF; op_buf[1] = 32'h0000_0002;
      run_full("u_sat", 32'h380, 2, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
      run_full("u_wrap", 32'h380, 2, 1'b0, 1'b0, 32'h0000_0001, 0);

      op_buf[0] = 32'hFFFF_FFFB; op_buf[1] = 32'h0000_0003;
      run_full("s_small", 32'h3C0, 2, 1'b1, 1'b1, 32'hFFFF_FFFE, 0);

      run_full("len0", 32'h500, 0, 1'b0, 1'b0, 32'h0, 0);

      // bus error on the third of five reads
      for (int i = 0; i < 5; i++) op_buf[i] = 32'(i + 1);
      plan = '{R_ACK, R_ACK, R_ERR};
      start_op(32'h600, 5, 1'b0, 1'b0);
      wait_end(c);
      check("err_flag", {equation_error, equation_done, bus.wb_cyc_o}, 64'b100);
      check("err_strobes", 64'(strobe_cnt), 64'd3);
      check("err_writes", 64'(wr_cnt), 64'd0);
      finish_op();

      op_buf[0] = 32'd10; op_buf[1] = 32'd20; op_buf[2] = 32'd30;
      plan = '{R_RTY, R_RTY};
      run_full("retry2", 32'h700, 3, 1'b0, 1'b0, 32'd60, 4);

      op_buf[0] = 32'd7; op_buf[1] = 32'd8;
      plan = '{R_RTY, R_RTY, R_RTY, R_ACK, R_RTY, R_RTY, R_RTY};
      run_full("retry_rearm", 32'h780, 2, 1'b0, 1'b0, 32'd15, 12);

      plan = '{R_RTY, R_RTY, R_RTY, R_RTY};
      start_op(32'h800, 2, 1'b0, 1'b0);
      wait_end(c);
      check("rty_max_flag", {equation_error, equation_done}, 64'b10);
      check("rty_max_strobes", 64'(strobe_cnt), 64'd4);
      check("rty_max_writes", 64'(wr_cnt), 64'd0);
      finish_op();

      // enable dropped mid-operation still completes
      op_buf[0] = 32'd100; op_buf[1] = 32'd200; op_buf[2] = 32'd300;
      start_op(32'hA00, 3, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge wb_clk);
         #1;
      end
      equation_enable = 1'b0;
      wait_end(c);
      check("drop_done", 64'(equation_done), 64'd1);
      check("drop_wr", {last_wr_adr, last_wr_dat}, {32'hA0C, 32'd600});
      finish_op();

      // asynchronous reset during a read
      op_buf[0] = 32'd5; op_buf[1] = 32'd6; op_buf[2] = 32'd7;
      start_op(32'h900, 3, 1'b0, 1'b0);
      c = 0;
      do begin
         @(posedge wb_clk);
         #1;
         c++;
      end while (!bus.wb_cyc_o && (c < 20));
      check("rst_mid_saw_cyc", 64'(bus.wb_cyc_o), 64'd1);
      #2;
      wb_rst_n        = 1'b0;
      equation_enable = 1'b0;
      #1;
      check("rst_mid_ctrl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 64'd0);
      check("rst_mid_adr", bus.wb_adr_o, 64'd0);
      @(negedge wb_clk);
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      flush();
      run_full("after_rst", 32'h900, 3, 1'b0, 1'b0, 32'd18, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
